// File: rtl/edge_delay_meter.sv
// Measures the clk-cycle delay between an edge on sig_ref and the matching edge on sig_dly.
// Optional macro EDGE_DELAY_METER_BOTH_EDGES_EN enables falling-edge measurement as well.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | waiting for the first synchronized sig_ref edge
// COUNT | counting cycles until the matching sig_dly edge or TIMEOUT
// DONE  | result presented, held until meas_valid && meas_ready
module edge_delay_meter #(
    parameter int CNT_BITS = 10,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sig_ref,
    input  logic                sig_dly,
    output logic                busy,
    output logic                meas_valid,
    input  logic                meas_ready,
    output logic [CNT_BITS-1:0] meas_delay,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    state_t                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [CNT_BITS-1:0]   cnt_d;
    logic [CNT_BITS-1:0]   meas_delay_q;
    logic                  timeout_q;
    logic                  valid_q;
    logic                  busy_q;

    // Identical synchronizer + edge-detect chains so the latency cancels.
    logic [1:0]            ref_sync_q;
    logic [1:0]            dly_sync_q;
    logic                  ref_prev_q;
    logic                  dly_prev_q;

    logic                  ref_rise;
    logic                  dly_rise;
    logic                  ref_edge;
    logic                  dly_hit_arm;
    logic                  dly_hit_cnt;

`ifdef EDGE_DELAY_METER_BOTH_EDGES_EN
    logic                  ref_fall;
    logic                  dly_fall;
    logic                  pol_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= 2'b00;
            dly_sync_q <= 2'b00;
            ref_prev_q <= 1'b0;
            dly_prev_q <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[0], sig_ref};
            dly_sync_q <= {dly_sync_q[0], sig_dly};
            ref_prev_q <= ref_sync_q[1];
            dly_prev_q <= dly_sync_q[1];
        end
    end

    always_comb begin
        ref_rise    = ref_sync_q[1] & ~ref_prev_q;
        dly_rise    = dly_sync_q[1] & ~dly_prev_q;
        ref_edge    = ref_rise;
        dly_hit_arm = dly_rise;
        dly_hit_cnt = dly_rise;
`ifdef EDGE_DELAY_METER_BOTH_EDGES_EN
        ref_fall    = ~ref_sync_q[1] & ref_prev_q;
        dly_fall    = ~dly_sync_q[1] & dly_prev_q;
        ref_edge    = ref_rise | ref_fall;
        // The delayed edge only counts when it has the reference's polarity.
        dly_hit_arm = ref_fall ? dly_fall : dly_rise;
        dly_hit_cnt = pol_q ? dly_fall : dly_rise;
`endif
    end

    assign cnt_d = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            meas_delay_q <= '0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifdef EDGE_DELAY_METER_BOTH_EDGES_EN
            pol_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (ref_edge) begin
`ifdef EDGE_DELAY_METER_BOTH_EDGES_EN
                        pol_q <= ref_fall;
`endif
                        if (dly_hit_arm) begin
                            state_q      <= DONE;
                            meas_delay_q <= '0;
                            timeout_q    <= 1'b0;
                            valid_q      <= 1'b1;
                        end else begin
                            // Cleared and advanced in one step: the first COUNT cycle reads 1.
                            state_q <= COUNT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                COUNT: begin
                    if (dly_hit_cnt) begin
                        state_q      <= DONE;
                        meas_delay_q <= cnt_q;
                        timeout_q    <= 1'b0;
                        valid_q      <= 1'b1;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q      <= DONE;
                        meas_delay_q <= TIMEOUT_C;
                        timeout_q    <= 1'b1;
                        valid_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    if (meas_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign meas_valid = valid_q;
    assign meas_delay = meas_delay_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_edge_delay_meter.sv
// Scoreboard bench for edge_delay_meter: stimulus pushes expected results, a monitor checks handshakes.
// Define EDGE_DELAY_METER_BOTH_EDGES_EN to also exercise falling-edge measurement.
`timescale 1ns/1ps
module tb_edge_delay_meter;

    localparam int CNT_BITS = 10;
    localparam int TIMEOUT  = 20;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                sig_ref;
    logic                sig_dly;
    logic                busy;
    logic                meas_valid;
    logic                meas_ready;
    logic [CNT_BITS-1:0] meas_delay;
    logic                timeout;

    typedef struct {
        int d;
        int t;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    edge_delay_meter #(.CNT_BITS(CNT_BITS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sig_ref    (sig_ref),
        .sig_dly    (sig_dly),
        .busy       (busy),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_delay (meas_delay),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got delay=%0d timeout=%0d expected no result at %0t",
                         meas_delay, timeout, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("meas_delay", 32'(meas_delay), 32'(e.d));
                chk("timeout", 32'(timeout), 32'(e.t));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int d, input int t);
        exp_t e;
        e.d = d;
        e.t = t;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic quiet();
        sig_ref = 1'b0;
        sig_dly = 1'b0;
        ticks(6);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!meas_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid_expired", 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_expired", 32'(n >= budget), 32'd0);
    endtask

    // ref rises, dly rises dly_at cycles later
    task automatic measure(input int dly_at, input int exp_d, input int exp_t);
        pulse_start();
        sig_ref = 1'b1;
        ticks(dly_at);
        sig_dly = 1'b1;
        push(exp_d, exp_t);
        wait_idle(60);
        quiet();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run expected finish before 100us");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit valid_seen;
        rst_n      = 1'b0;
        start      = 1'b0;
        sig_ref    = 1'b0;
        sig_dly    = 1'b0;
        meas_ready = 1'b1;
        ticks(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_delay", 32'(meas_delay), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // delay of 5, result held while meas_ready is low
        meas_ready = 1'b0;
        pulse_start();
        chk("armed_busy", 32'(busy), 32'd1);
        sig_ref = 1'b1;
        ticks(5);
        sig_dly = 1'b1;
        push(5, 0);
        wait_valid(30);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold5_valid", 32'(meas_valid), 32'd1);
            chk("hold5_delay", 32'(meas_delay), 32'd5);
        end
        meas_ready = 1'b1;
        wait_idle(20);
        quiet();

        // simultaneous edges in ARM
        pulse_start();
        sig_ref = 1'b1;
        sig_dly = 1'b1;
        push(0, 0);
        wait_idle(30);
        quiet();

        // no delayed edge: timeout at TIMEOUT
        pulse_start();
        sig_ref = 1'b1;
        push(TIMEOUT, 1);
        wait_idle(60);
        chk("after_timeout_busy", 32'(busy), 32'd0);
        quiet();

        // delayed edge on the terminal count wins; one short of it
        measure(20, 20, 0);
        measure(19, 19, 0);
        measure(1, 1, 0);

        // sig_dly edge in ARM without a reference edge is ignored
        pulse_start();
        sig_dly = 1'b1;
        ticks(3);
        sig_dly = 1'b0;
        ticks(3);
        sig_ref = 1'b1;
        ticks(3);
        sig_dly = 1'b1;
        push(3, 0);
        wait_idle(30);
        quiet();

        // later reference edges in COUNT are ignored
        pulse_start();
        sig_ref = 1'b1;
        ticks(3);
        sig_ref = 1'b0;
        ticks(3);
        sig_ref = 1'b1;
        ticks(2);
        sig_dly = 1'b1;
        push(8, 0);
        wait_idle(30);
        quiet();

        // DONE with ready low for 10 cycles: start and edges ignored
        meas_ready = 1'b0;
        pulse_start();
        sig_ref = 1'b1;
        ticks(4);
        sig_dly = 1'b1;
        push(4, 0);
        wait_valid(30);
        for (int i = 0; i < 10; i++) begin
            start = (i == 2);
            if (i == 4) begin
                sig_ref = 1'b0;
                sig_dly = 1'b0;
            end
            if (i == 7) begin
                sig_ref = 1'b1;
                sig_dly = 1'b1;
            end
            tick();
            chk("done_valid", 32'(meas_valid), 32'd1);
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_delay", 32'(meas_delay), 32'd4);
            chk("done_timeout", 32'(timeout), 32'd0);
        end
        start      = 1'b1;
        meas_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_valid", 32'(meas_valid), 32'd0);
        ticks(3);
        chk("hs_start_ignored", 32'(busy), 32'd0);
        chk("hs_queue_empty", 32'(q.size()), 32'd0);
        quiet();

        // reset in the middle of COUNT
        pulse_start();
        sig_ref = 1'b1;
        ticks(6);
        chk("precount_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_valid", 32'(meas_valid), 32'd0);
        chk("rstmid_delay", 32'(meas_delay), 32'd0);
        chk("rstmid_timeout", 32'(timeout), 32'd0);
        tick();
        rst_n   = 1'b1;
        sig_dly = 1'b1;
        valid_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (meas_valid || busy) valid_seen = 1'b1;
        end
        chk("post_rst_no_valid", 32'(valid_seen), 32'd0);
        quiet();
        measure(2, 2, 0);

`ifdef EDGE_DELAY_METER_BOTH_EDGES_EN
        // ref fall, dly rise at 3 is the wrong polarity, dly fall at 7 matches
        sig_ref = 1'b1;
        sig_dly = 1'b0;
        ticks(6);
        pulse_start();
        sig_ref = 1'b0;
        ticks(3);
        sig_dly = 1'b1;
        ticks(4);
        sig_dly = 1'b0;
        push(7, 0);
        wait_idle(40);
        quiet();
`endif

        ticks(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_delay_meter.md
EDGE_DELAY_METER -- requirements
Module: edge_delay_meter

Interface
REQ-001 The block SHALL have parameter CNT_BITS, default 10, which sets the width of the delay count.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, which sets the maximum count before the measurement is abandoned; it SHALL satisfy 1 <= TIMEOUT <= 2^CNT_BITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to arm a measurement.
REQ-006 The block SHALL have port sig_ref, input, 1 bit: the asynchronous reference signal, i.e. the undelayed clock or strobe.
REQ-007 The block SHALL have port sig_dly, input, 1 bit: the asynchronous delayed copy of sig_ref, as produced by a delay chain.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port meas_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port meas_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port meas_delay, output, CNT_BITS bits: the measured delay in clk cycles.
REQ-012 The block SHALL have port timeout, output, 1 bit: the result is a timeout and not a valid measurement.

Function
REQ-013 sig_ref and sig_dly SHALL each pass through an identical 2-flop synchronizer followed by a 1-flop edge detector, so that both paths have equal latency and the synchronizer latency cancels in the difference.
REQ-014 The FSM SHALL have the states IDLE, ARM, COUNT and DONE.
REQ-015 IDLE -> ARM: taken on start=1; start SHALL be ignored in every other state.
REQ-016 ARM transitions:
- On a detected sig_ref edge, the block SHALL clear the counter and go to COUNT.
- If a sig_dly edge is detected in the same cycle as the sig_ref edge, the block SHALL instead go to DONE with meas_delay=0 and timeout=0.
- A sig_dly edge without a sig_ref edge SHALL be ignored.
REQ-017 COUNT: the counter SHALL increment by 1 on every cycle, so its value is 1 in the first cycle after the reference edge.
REQ-018 COUNT -> DONE on a sig_dly edge: meas_delay SHALL be loaded with the current counter value and timeout with 0.
REQ-019 COUNT -> DONE when the counter equals TIMEOUT with no sig_dly edge: meas_delay SHALL be loaded with TIMEOUT and timeout with 1; the counter SHALL never wrap.
REQ-020 If a sig_dly edge and counter==TIMEOUT occur in the same cycle, the sig_dly edge SHALL take precedence and timeout SHALL be 0.
REQ-021 Further sig_ref edges in COUNT SHALL be ignored; only the first reference edge is measured.
REQ-022 DONE: meas_valid SHALL be 1, and meas_delay and timeout SHALL be held stable until meas_valid and meas_ready are both 1.
REQ-023 DONE -> IDLE on that handshake cycle; meas_valid SHALL drop on the following cycle.
REQ-024 A start asserted in the same cycle as the DONE handshake SHALL be ignored.
REQ-025 meas_valid SHALL never depend combinationally on meas_ready.
REQ-026 The earliest possible result for a delay of d cycles SHALL appear with meas_valid high 1 cycle after the synchronized sig_dly edge is detected.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously force: FSM=IDLE, counter=0, meas_delay=0, timeout=0, meas_valid=0, busy=0, and all synchronizer and edge flops=0.
REQ-028 A reset in any state, including DONE with meas_valid=1, SHALL abort the measurement and discard the result.
REQ-029 After rst_n rises, the first start SHALL be accepted no earlier than the first rising clk edge.
REQ-030 Because the edge-detect flops reset to 0, a sig_ref that is already high when reset is released SHALL produce one rising edge 3 cycles later, and this edge is valid if the block is armed.

Configuration
REQ-031 With the macro EDGE_DELAY_METER_BOTH_EDGES_EN defined, rising and falling edges of both signals SHALL be detected.
REQ-032 With EDGE_DELAY_METER_BOTH_EDGES_EN defined, ARM SHALL accept either polarity of sig_ref edge, and COUNT SHALL accept only a sig_dly edge of the same polarity as the captured reference edge.
REQ-033 With EDGE_DELAY_METER_BOTH_EDGES_EN undefined, only rising edges SHALL be detected and the falling-edge logic SHALL be absent.

Verification
REQ-034 The bench SHALL cover: start, then a sig_ref rise followed 5 cycles later by a sig_dly rise -> meas_delay=5, timeout=0, meas_valid held until meas_ready=1.
REQ-035 The bench SHALL cover: sig_ref and sig_dly rising in the same cycle while in ARM -> meas_delay=0, timeout=0.
REQ-036 The bench SHALL cover: TIMEOUT=20 with no sig_dly edge -> meas_delay=20, timeout=1, returning to IDLE after the handshake.
REQ-037 The bench SHALL cover: meas_ready held 0 for 10 cycles in DONE, with start and new edges applied -> outputs unchanged, busy=1, start ignored.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-COUNT -> all outputs 0 immediately, with no meas_valid afterwards until a new start.
REQ-039 The bench SHALL cover, with EDGE_DELAY_METER_BOTH_EDGES_EN defined: a sig_ref fall followed by a sig_dly rise at 3 cycles and a sig_dly fall at 7 cycles -> meas_delay=7.
